// File: rtl/rhythm_lane_judge.sv
// rhythm_lane_judge
//   Judges button pushes on four independent lanes against a per-lane timing
//   window. Each lane is armed by a note pulse and judged PERFECT, GOOD or
//   MISS. It also keeps the running score, the current combo and the maximum
//   combo for the display logic.
//
// Ports
//   i_Clk       system clock
//   i_Rst       synchronous active-high reset
//   i_Clear     synchronous game restart (same effect as i_Rst)
//   i_Tick      one-cycle timing enable that advances armed windows
//   i_fPush[3:0]  one-cycle push pulses, one bit per lane
//   i_Note[3:0]   one-cycle pulses that open a lane's judgement window
//   o_Perfect/o_Good/o_Miss[3:0]  registered one-cycle judgement pulses
//   o_Score[15:0]      accumulated score, saturating at 16'hFFFF
//   o_Combo[9:0]       current combo, saturating at 1023
//   o_MaxCombo[9:0]    highest combo since reset/clear
module rhythm_lane_judge #(
  parameter int WIN_LEN  = 20,
  parameter int PERF_LO  = 8,
  parameter int PERF_HI  = 11,
  parameter int PERF_PTS = 2,
  parameter int GOOD_PTS = 1
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Clear,
  input  logic        i_Tick,
  input  logic [3:0]  i_fPush,
  input  logic [3:0]  i_Note,
  output logic [3:0]  o_Perfect,
  output logic [3:0]  o_Good,
  output logic [3:0]  o_Miss,
  output logic [15:0] o_Score,
  output logic [9:0]  o_Combo,
  output logic [9:0]  o_MaxCombo
);

  localparam int CNT_W = $clog2(WIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] PERF_LO_C = CNT_W'(PERF_LO);
  localparam logic [CNT_W-1:0] PERF_HI_C = CNT_W'(PERF_HI);

  typedef enum logic {IDLE, ARMED} lane_state_t;

  lane_state_t      lane_state [4];
  lane_state_t      lane_state_nxt [4];
  logic [CNT_W-1:0] lane_cnt [4];
  logic [CNT_W-1:0] lane_cnt_nxt [4];

  logic [3:0]  perf_p0, good_p0, miss_p0;
  logic [16:0] score_sum_p0;
  logic [10:0] combo_sum_p0;
  logic [9:0]  combo_nxt_p0, max_nxt_p0;

  logic [3:0]  perfect_p1, good_p1, miss_p1;
  logic [15:0] score_p1;
  logic [9:0]  combo_p1, max_combo_p1;

  logic clr;
  assign clr = i_Rst | i_Clear;

  function automatic logic in_perfect(input logic [CNT_W-1:0] c);
    return (c >= PERF_LO_C) && (c <= PERF_HI_C);
  endfunction

  function automatic logic [2:0] count4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  function automatic logic [15:0] sat_score(input logic [16:0] s);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [9:0] sat_combo(input logic [10:0] s);
    return s[10] ? 10'h3FF : s[9:0];
  endfunction

  // Stage p0: per-lane judgement and next lane state
  always_comb begin
    lane_state_nxt = lane_state;
    lane_cnt_nxt   = lane_cnt;
    perf_p0        = '0;
    good_p0        = '0;
    miss_p0        = '0;
    for (int n = 0; n < 4; n++) begin
      unique case (lane_state[n])
        IDLE: begin
          if (i_Note[n]) begin
            if (i_fPush[n]) begin
              // Note and push together: judged at once against cnt=0.
              perf_p0[n] = in_perfect('0);
              good_p0[n] = !in_perfect('0);
            end else begin
              lane_state_nxt[n] = ARMED;
              lane_cnt_nxt[n]   = '0;
            end
          end
        end
        ARMED: begin
          if (i_fPush[n]) begin
            // Push wins over a same-cycle tick: judged on the pre-increment count.
            perf_p0[n]        = in_perfect(lane_cnt[n]);
            good_p0[n]        = !in_perfect(lane_cnt[n]);
            lane_cnt_nxt[n]   = '0;
            lane_state_nxt[n] = i_Note[n] ? ARMED : IDLE;
          end else if (i_Note[n]) begin
            // A fresh note abandons the pending one.
            miss_p0[n]      = 1'b1;
            lane_cnt_nxt[n] = '0;
          end else if (i_Tick) begin
            if (lane_cnt[n] == CNT_LAST) begin
              miss_p0[n]        = 1'b1;
              lane_cnt_nxt[n]   = '0;
              lane_state_nxt[n] = IDLE;
            end else begin
              lane_cnt_nxt[n] = lane_cnt[n] + 1'b1;
            end
          end
        end
        default: lane_state_nxt[n] = IDLE;
      endcase
    end

    score_sum_p0 = {1'b0, score_p1}
                 + 17'(PERF_PTS) * 17'(count4(perf_p0))
                 + 17'(GOOD_PTS) * 17'(count4(good_p0));
    combo_sum_p0 = {1'b0, combo_p1} + 11'(count4(perf_p0)) + 11'(count4(good_p0));
    combo_nxt_p0 = (|miss_p0) ? 10'd0 : sat_combo(combo_sum_p0);
    max_nxt_p0   = (combo_nxt_p0 > max_combo_p1) ? combo_nxt_p0 : max_combo_p1;
  end

  // Stage p1: lane state, judgement pulses and totals
  always_ff @(posedge i_Clk) begin
    if (clr) begin
      for (int n = 0; n < 4; n++) begin
        lane_state[n] <= IDLE;
        lane_cnt[n]   <= '0;
      end
      perfect_p1   <= '0;
      good_p1      <= '0;
      miss_p1      <= '0;
      score_p1     <= '0;
      combo_p1     <= '0;
      max_combo_p1 <= '0;
    end else begin
      lane_state   <= lane_state_nxt;
      lane_cnt     <= lane_cnt_nxt;
      perfect_p1   <= perf_p0;
      good_p1      <= good_p0;
      miss_p1      <= miss_p0;
      score_p1     <= sat_score(score_sum_p0);
      combo_p1     <= combo_nxt_p0;
      max_combo_p1 <= max_nxt_p0;
    end
  end

  assign o_Perfect  = perfect_p1;
  assign o_Good     = good_p1;
  assign o_Miss     = miss_p1;
  assign o_Score    = score_p1;
  assign o_Combo    = combo_p1;
  assign o_MaxCombo = max_combo_p1;

endmodule

// File: tb/tb_rhythm_lane_judge.sv
// Testbench for rhythm_lane_judge: directed scenarios plus randomized traffic,
// all compared against a behavioural model of note windows, score and combo.
module tb_rhythm_lane_judge;

  localparam int WIN_LEN  = 20;
  localparam int PERF_LO  = 8;
  localparam int PERF_HI  = 11;
  localparam int PERF_PTS = 2;
  localparam int GOOD_PTS = 1;

  logic        clk = 1'b0;
  logic        rst, clear, tick;
  logic [3:0]  push, note;
  logic [3:0]  perfect, good, miss;
  logic [15:0] score;
  logic [9:0]  combo, max_combo;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: whether each lane holds an open note and how many ticks old it is.
  bit         pend [4];
  int         age  [4];
  int         m_score, m_combo, m_max;
  logic [3:0] e_perf, e_good, e_miss;

  always #5 clk = ~clk;

  rhythm_lane_judge #(
    .WIN_LEN(WIN_LEN), .PERF_LO(PERF_LO), .PERF_HI(PERF_HI),
    .PERF_PTS(PERF_PTS), .GOOD_PTS(GOOD_PTS)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Clear(clear), .i_Tick(tick),
    .i_fPush(push), .i_Note(note),
    .o_Perfect(perfect), .o_Good(good), .o_Miss(miss),
    .o_Score(score), .o_Combo(combo), .o_MaxCombo(max_combo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    int np, ng;
    e_perf = '0;
    e_good = '0;
    e_miss = '0;
    if (rst || clear) begin
      for (int n = 0; n < 4; n++) begin
        pend[n] = 0;
        age[n]  = 0;
      end
      m_score = 0;
      m_combo = 0;
      m_max   = 0;
      return;
    end
    for (int n = 0; n < 4; n++) begin
      if (push[n] && (pend[n] || note[n])) begin
        int a;
        a = pend[n] ? age[n] : 0;
        if (a >= PERF_LO && a <= PERF_HI) e_perf[n] = 1'b1;
        else e_good[n] = 1'b1;
        pend[n] = pend[n] && note[n];
        age[n]  = 0;
      end else if (note[n]) begin
        if (pend[n]) e_miss[n] = 1'b1;
        pend[n] = 1;
        age[n]  = 0;
      end else if (tick && pend[n]) begin
        if (age[n] == WIN_LEN - 1) begin
          e_miss[n] = 1'b1;
          pend[n]   = 0;
        end else begin
          age[n]++;
        end
      end
    end
    np = $countones(e_perf);
    ng = $countones(e_good);
    m_score = m_score + PERF_PTS * np + GOOD_PTS * ng;
    if (m_score > 65535) m_score = 65535;
    if (e_miss != 0) m_combo = 0;
    else m_combo = (m_combo + np + ng > 1023) ? 1023 : m_combo + np + ng;
    if (m_combo > m_max) m_max = m_combo;
  endtask

  // Apply the currently driven inputs for one clock, check, then idle the inputs.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("perfect", 32'(perfect), 32'(e_perf));
    chk("good", 32'(good), 32'(e_good));
    chk("miss", 32'(miss), 32'(e_miss));
    chk("score", 32'(score), 32'(m_score));
    chk("combo", 32'(combo), 32'(m_combo));
    chk("max_combo", 32'(max_combo), 32'(m_max));
    rst = 0; clear = 0; tick = 0; push = '0; note = '0;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) begin
      tick = 1;
      cycle();
    end
  endtask

  initial begin
    rst = 1; clear = 0; tick = 0; push = '0; note = '0;
    cycle();
    chk("reset_score", 32'(score), 0);
    chk("reset_pulses", 32'({perfect, good, miss}), 0);

    // Lane 0 perfect at cnt=9
    note = 4'b0001; cycle();
    ticks(9);
    push = 4'b0001; cycle();
    chk("t1_perfect", 32'(perfect), 32'h1);
    chk("t1_score", 32'(score), 2);
    chk("t1_combo", 32'(combo), 1);
    chk("t1_max", 32'(max_combo), 1);

    // Lane 1 good at cnt=2, then push on an idle lane
    note = 4'b0010; cycle();
    ticks(2);
    push = 4'b0010; cycle();
    chk("t2_good", 32'(good), 32'h2);
    chk("t2_score", 32'(score), 3);
    push = 4'b1000; cycle();
    chk("t2_idle_pulses", 32'({perfect, good, miss}), 0);
    chk("t2_idle_score", 32'(score), 3);

    // Lane 2 expires after 20 ticks
    note = 4'b0100; cycle();
    ticks(19);
    chk("t3_no_early_miss", 32'(miss), 0);
    ticks(1);
    chk("t3_miss", 32'(miss), 32'h4);
    chk("t3_combo", 32'(combo), 0);
    chk("t3_max", 32'(max_combo), 2);

    // Three perfects and a miss in one cycle
    note = 4'b0100; cycle();
    ticks(9);
    note = 4'b1011; cycle();
    ticks(10);
    push = 4'b1011; tick = 1; cycle();
    chk("t4_perfect", 32'(perfect), 32'hB);
    chk("t4_miss", 32'(miss), 32'h4);
    chk("t4_score", 32'(score), 9);
    chk("t4_combo", 32'(combo), 0);

    // Re-note on an armed lane misses and restarts
    note = 4'b0001; cycle();
    ticks(5);
    note = 4'b0001; cycle();
    chk("t5_renote_miss", 32'(miss), 32'h1);
    ticks(8);
    push = 4'b0001; cycle();
    chk("t5_perfect", 32'(perfect), 32'h1);
    chk("t5_score", 32'(score), 11);
    chk("t5_combo", 32'(combo), 1);

    // Randomized traffic, including clears and resets
    for (int i = 0; i < 3000; i++) begin
      tick = ($urandom_range(1, 0) == 1);
      for (int n = 0; n < 4; n++) begin
        note[n] = ($urandom_range(29, 0) == 0);
        push[n] = ($urandom_range(11, 0) == 0);
      end
      clear = ($urandom_range(499, 0) == 0);
      rst   = ($urandom_range(699, 0) == 0);
      cycle();
    end

    // Score preload towards saturation
    rst = 1; cycle();
    note = 4'b1111; cycle();
    for (int k = 0; k < 8191; k++) begin
      ticks(8);
      note = 4'b1111; push = 4'b1111; cycle();
    end
    chk("pre_score", 32'(score), 65528);
    chk("pre_combo_sat", 32'(combo), 1023);
    push = 4'b1111; cycle();
    chk("pre_good4", 32'(good), 32'hF);
    note = 4'b0011; push = 4'b0011; cycle();
    chk("pre_score_fffe", 32'(score), 32'hFFFE);
    note = 4'b1111; cycle();
    ticks(8);
    push = 4'b1111; cycle();
    chk("sat_perfect", 32'(perfect), 32'hF);
    chk("sat_score", 32'(score), 32'hFFFF);
    chk("sat_combo", 32'(combo), 1023);

    // Reset while armed, with competing inputs
    note = 4'b1111; cycle();
    ticks(3);
    rst = 1; push = 4'b1111; tick = 1; cycle();
    chk("rst_outputs", 32'({perfect, good, miss}), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_max", 32'(max_combo), 0);
    for (int i = 0; i < 25; i++) begin
      tick = 1;
      cycle();
      chk("rst_no_pulse", 32'({perfect, good, miss}), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
